// File: rtl/serial_target_receiver.sv
// Mode-0 serial target: synchronises sck/cs_n/mosi into clk, deserialises mosi into
// words and shifts a transmit word out on miso, MSB first.
module serial_target_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ack,
    output logic                  busy,
    output logic                  frame_abort
);
    // state  | meaning
    // IDLE   | no frame; sck edges ignored, miso released
    // ACTIVE | frame selected; shifting rx/tx on sck edges

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sck_sync;
    logic [SYNC_STAGES-1:0]  cs_sync;
    logic [SYNC_STAGES-1:0]  mosi_sync;
    logic [SYNC_STAGES-1:0]  fill;
    logic                    sck_q;
    logic                    armed;
    logic                    sck_s;
    logic                    cs_s;
    logic                    mosi_s;
    logic                    sck_rise;
    logic                    sck_fall;
    logic [CW-1:0]           bit_cnt;
    logic [DATA_WIDTH-1:0]   rx_shift;
    logic [DATA_WIDTH-1:0]   tx_shift;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_q;
    assign sck_fall = ~sck_s & sck_q;
    assign miso     = miso_oe & tx_shift[DATA_WIDTH-1];

    // armed only sets once a genuine pin sample of cs_n high has reached the
    // end of the chain, so a frame interrupted by reset is not re-entered
    // until cs_n has gone high and low again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sck_q     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sck_q     <= sck_s;
            if (fill[SYNC_STAGES-1] && cs_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            miso_oe     <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_ack      <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_ack      <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (armed && !cs_s) begin
                        state   <= ACTIVE;
                        busy    <= 1'b1;
                        miso_oe <= 1'b1;
                        bit_cnt <= '0;
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            tx_ack   <= 1'b1;
                        end else begin
                            tx_shift <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    // cs_n release wins over any sck edge seen in the same clk
                    if (cs_s) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        miso_oe  <= 1'b0;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                        if (bit_cnt != '0)
                            frame_abort <= 1'b1;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                        if (bit_cnt == LAST) begin
                            bit_cnt  <= '0;
                            rx_data  <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                            rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (sck_fall) begin
                        if (bit_cnt == '0) begin
                            if (tx_valid) begin
                                tx_shift <= tx_data;
                                tx_ack   <= 1'b1;
                            end else begin
                                tx_shift <= '0;
                            end
                        end else begin
                            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_target_receiver.sv
// Bench for serial_target_receiver: directed and random frames driven as an initiator,
// checked against word-level expectations (rx words, miso bits, ack/abort counts).
module tb_serial_target_receiver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ack;
    logic       busy;
    logic       frame_abort;

    int n_checks = 0;
    int n_fail   = 0;

    int rx_cnt = 0;
    int ack_cnt = 0;
    int abort_cnt = 0;
    logic [7:0] rx_log[$];

    logic [7:0] mo_w[8];
    logic [7:0] tx_w[8];
    bit         tv[8];

    serial_target_receiver #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack), .busy(busy),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            rx_log.push_back(rx_data);
        end
        if (tx_ack) ack_cnt++;
        if (frame_abort) abort_cnt++;
    end

    // Drives one cs_n-framed transfer of nbits bits using mo_w/tx_w/tv, then
    // checks miso per bit, received words, ack and abort counts.
    task automatic run_frame(input int nbits, input int ph, input string tag);
        int nfull, exp_ack, ack0, abort0, w, i;
        logic exp_bit;
        nfull = nbits / 8;
        exp_ack = 0;
        for (int j = 0; j <= nfull; j++) if (tv[j]) exp_ack++;
        ack0 = ack_cnt;
        abort0 = abort_cnt;
        rx_log.delete();
        tx_data = tx_w[0];
        tx_valid = tv[0];
        sck = 1'b0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            w = b / 8;
            i = 7 - (b % 8);
            mosi = mo_w[w][i];
            repeat (ph) @(negedge clk);
            exp_bit = tv[w] ? tx_w[w][i] : 1'b0;
            n_checks++;
            if (miso !== exp_bit || miso_oe !== 1'b1) begin
                n_fail++;
                $display("FAIL %s miso bit %0d: got miso=%b oe=%b, want miso=%b oe=1", tag, b, miso, miso_oe, exp_bit);
            end
            sck = 1'b1;
            if (b % 8 == 7) begin
                tx_data = tx_w[w+1];
                tx_valid = tv[w+1];
            end
            repeat (ph) @(negedge clk);
            sck = 1'b0;
        end
        repeat (ph) @(negedge clk);
        cs_n = 1'b1;
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++;
        if (rx_log.size() != nfull) begin
            n_fail++;
            $display("FAIL %s rx word count: got %0d, want %0d", tag, rx_log.size(), nfull);
        end else begin
            for (int k = 0; k < nfull; k++) begin
                n_checks++;
                if (rx_log[k] !== mo_w[k]) begin
                    n_fail++;
                    $display("FAIL %s rx word %0d: got %h, want %h", tag, k, rx_log[k], mo_w[k]);
                end
            end
        end
        n_checks++;
        if (ack_cnt - ack0 != exp_ack) begin
            n_fail++;
            $display("FAIL %s tx_ack count: got %0d, want %0d", tag, ack_cnt - ack0, exp_ack);
        end
        n_checks++;
        if (abort_cnt - abort0 != ((nbits % 8 != 0) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s frame_abort count: got %0d, want %0d", tag, abort_cnt - abort0, (nbits % 8 != 0) ? 1 : 0);
        end
        n_checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle after frame: got busy=%b oe=%b, want 0 0", tag, busy, miso_oe);
        end
    endtask

    task automatic setup(input int nw);
        for (int j = 0; j < 8; j++) begin
            mo_w[j] = 8'h00;
            tx_w[j] = 8'h00;
            tv[j] = 1'b0;
        end
    endtask

    task automatic test_reset;
        int rx0;
        rst_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sck = ~sck;
            repeat (2) @(negedge clk);
        end
        n_checks++;
        if ({miso, miso_oe, rx_data, rx_valid, tx_ack, busy, frame_abort} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset outputs: got miso=%b oe=%b rx=%h rv=%b ack=%b busy=%b ab=%b, want all 0",
                     miso, miso_oe, rx_data, rx_valid, tx_ack, busy, frame_abort);
        end
        sck = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        rx0 = rx_cnt;
        for (int k = 0; k < 20; k++) begin
            sck = ~sck;
            repeat (4) @(negedge clk);
            n_checks++;
            if (miso_oe !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle sck toggle %0d: got oe=%b busy=%b, want 0 0", k, miso_oe, busy);
            end
        end
        sck = 1'b0;
        n_checks++;
        if (rx_cnt != rx0) begin
            n_fail++;
            $display("FAIL idle rx_valid: got %0d pulses, want 0", rx_cnt - rx0);
        end
    endtask

    task automatic test_single_word;
        setup(1);
        mo_w[0] = 8'h3C; tx_w[0] = 8'hA5; tv[0] = 1'b1;
        run_frame(8, 8, "single");
        n_checks++;
        if (rx_data !== 8'h3C) begin
            n_fail++;
            $display("FAIL single rx_data: got %h, want 3c", rx_data);
        end
    endtask

    task automatic test_back_to_back;
        setup(2);
        mo_w[0] = 8'hFF; mo_w[1] = 8'h01;
        tx_w[0] = 8'hA5; tx_w[1] = 8'h5A; tv[0] = 1'b1; tv[1] = 1'b1;
        run_frame(16, 8, "two_word");
    endtask

    task automatic test_underrun;
        setup(1);
        mo_w[0] = 8'h96; tx_w[0] = 8'hFF; tv[0] = 1'b0;
        run_frame(8, 6, "underrun");
    endtask

    task automatic test_abort;
        setup(1);
        mo_w[0] = 8'hE7; tx_w[0] = 8'h33; tv[0] = 1'b1;
        run_frame(5, 6, "abort");
        setup(1);
        mo_w[0] = 8'h81; tx_w[0] = 8'h18; tv[0] = 1'b1;
        run_frame(8, 6, "after_abort");
        n_checks++;
        if (rx_data !== 8'h81) begin
            n_fail++;
            $display("FAIL after_abort rx_data: got %h, want 81", rx_data);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] junk;
        junk = 8'hFF;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            mosi = junk[7-b];
            repeat (5) @(negedge clk);
            sck = 1'b1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || miso_oe !== 1'b0 || rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset outputs: got busy=%b oe=%b rv=%b, want 0 0 0", busy, miso_oe, rx_valid);
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid reset re-entry with cs_n held low: got busy=%b, want 0", busy);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        setup(1);
        mo_w[0] = 8'hC3; tx_w[0] = 8'h7E; tv[0] = 1'b1;
        run_frame(8, 5, "after_reset");
        n_checks++;
        if (rx_data !== 8'hC3) begin
            n_fail++;
            $display("FAIL after_reset rx_data: got %h, want c3", rx_data);
        end
    endtask

    task automatic test_random;
        int nw, nbits, ph;
        for (int it = 0; it < 20; it++) begin
            setup(0);
            nw = $urandom_range(3, 1);
            nbits = nw * 8;
            if ($urandom_range(3, 0) == 0) nbits = (nw - 1) * 8 + $urandom_range(7, 1);
            ph = $urandom_range(9, 4);
            for (int j = 0; j < nw; j++) begin
                mo_w[j] = 8'($urandom);
                tx_w[j] = 8'($urandom);
                tv[j] = ($urandom_range(3, 0) != 0);
            end
            run_frame(nbits, ph, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_back_to_back;
        test_underrun;
        test_abort;
        test_reset_mid_word;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
